// File: rtl/wb_sram_ctrl.sv
// Wishbone-classic slave driving an external asynchronous SRAM.
// 32-bit or big-endian split 16-bit SRAM, with programmable wait states.
module wb_sram_ctrl #(
  parameter int AW      = 18,
  parameter int SRAM_DW = 32,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [SRAM_DW-1:0] sram_dat_i,
  output logic [SRAM_DW-1:0] sram_dat_o,
  output logic               sram_dat_oe_o,
  output logic [AW-1:0]      sram_addr_o,
  output logic [SRAM_DW/8-1:0] sram_bsel_o,
  output logic               sram_ncs_o,
  output logic               sram_noe_o,
  output logic               sram_nwe_o
);

  localparam int BW = SRAM_DW / 8;
  localparam logic [3:0] LP_RW = 4'(RD_WAIT);
  localparam logic [3:0] LP_WW = 4'(WR_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTRB,
    S_WSETUP,
    S_WSTRB,
    S_WHOLD,
    S_NEXT,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_nxt;
  state_t w_end;

  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt;
  logic          r_half;
  logic          w_half;
  logic          r_abort;
  logic          w_abort_n;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdat;

  logic [31:0]   r_dat_o;
  logic          r_ack;
  logic [SRAM_DW-1:0] r_sdat;
  logic          r_oe;
  logic [AW-1:0] r_saddr;
  logic [BW-1:0] r_bsel;
  logic          r_ncs;
  logic          r_noe;
  logic          r_nwe;

  logic          w_idle;
  logic          w_req;
  logic          w_abort;
  logic          w_cap;
  logic          w_acc;
  logic          w_wr;
  logic [AW-1:0] w_adr;
  logic [3:0]    w_sel;
  logic [31:0]   w_wdat;
  logic          w_h0;
  logic          w_h1;
  logic [AW-1:0] w_sa;
  logic [BW-1:0] w_sb;
  logic [SRAM_DW-1:0] w_sd;
  logic [31:0]   w_rmask;
  logic [31:0]   w_cap_dat;
  logic          w_unused;

  assign w_idle  = (r_state == S_IDLE);
  assign w_req   = wb_cyc_i & wb_stb_i;
  assign w_abort = r_abort | ~wb_cyc_i;

  // In IDLE the access is set up straight from the bus, later from latches
  assign w_adr  = w_idle ? wb_adr_i[AW+1:2] : r_adr;
  assign w_sel  = w_idle ? wb_sel_i : r_sel;
  assign w_wdat = w_idle ? wb_dat_i : r_wdat;

  assign w_rmask = {{8{r_sel[3]}}, {8{r_sel[2]}},
                    {8{r_sel[1]}}, {8{r_sel[0]}}};

  assign w_unused = ^{wb_adr_i[1:0], wb_adr_i[31:AW+2]};

  if (SRAM_DW == 32) begin : g_dw32
    assign w_h0 = |w_sel;
    assign w_h1 = 1'b0;
    assign w_sa = w_adr;
    assign w_sb = ~w_sel;
    assign w_sd = w_wdat;
    assign w_cap_dat = sram_dat_i & w_rmask;
  end else begin : g_dw16
    logic w_unused_msb;
    assign w_unused_msb = w_adr[AW-1];
    assign w_h0 = |w_sel[3:2];
    assign w_h1 = |w_sel[1:0];
    assign w_sa = {w_adr[AW-2:0], w_half};
    assign w_sb = w_half ? ~w_sel[1:0] : ~w_sel[3:2];
    assign w_sd = w_half ? w_wdat[15:0] : w_wdat[31:16];
    assign w_cap_dat = r_half ?
      {r_dat_o[31:16], sram_dat_i & w_rmask[15:0]} :
      {sram_dat_i & w_rmask[31:16], r_dat_o[15:0]};
  end

  assign w_end = w_abort ? S_IDLE :
                 (~r_half & w_h1) ? S_NEXT : S_ACK;

  always_comb begin
    w_nxt     = r_state;
    w_cnt     = r_cnt;
    w_half    = r_half;
    w_abort_n = r_abort;
    w_cap     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt     = 4'd0;
        w_abort_n = 1'b0;
        if (w_req) begin
          if (!(w_h0 | w_h1)) begin
            w_nxt = S_ACK;
          end else begin
            w_half = ~w_h0;
            w_nxt  = wb_we_i ? S_WSETUP : S_RSTRB;
          end
        end
      end
      S_RSTRB: begin
        w_abort_n = w_abort;
        if (r_cnt == LP_RW) begin
          w_cap = 1'b1;
          w_cnt = 4'd0;
          w_nxt = w_end;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_WSETUP: begin
        w_abort_n = w_abort;
        w_nxt     = S_WSTRB;
      end
      S_WSTRB: begin
        w_abort_n = w_abort;
        if (r_cnt == LP_WW) begin
          w_cnt = 4'd0;
          w_nxt = S_WHOLD;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_WHOLD: begin
        w_abort_n = w_abort;
        w_nxt     = w_end;
      end
      S_NEXT: begin
        if (w_abort) begin
          w_nxt = S_IDLE;
        end else begin
          w_half = 1'b1;
          w_nxt  = r_we ? S_WSETUP : S_RSTRB;
        end
      end
      S_ACK:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_half  <= 1'b0;
      r_abort <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= 4'd0;
      r_wdat  <= 32'd0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_half  <= w_half;
      r_abort <= w_abort_n;
      if (w_idle && w_req) begin
        r_we   <= wb_we_i;
        r_adr  <= wb_adr_i[AW+1:2];
        r_sel  <= wb_sel_i;
        r_wdat <= wb_dat_i;
      end
    end
  end

  // Pins are loaded from the next state so every output is a flop
  assign w_acc = (w_nxt == S_RSTRB) || (w_nxt == S_WSETUP) ||
                 (w_nxt == S_WSTRB) || (w_nxt == S_WHOLD);
  assign w_wr  = (w_nxt == S_WSETUP) || (w_nxt == S_WSTRB) ||
                 (w_nxt == S_WHOLD);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dat_o <= 32'd0;
      r_ack   <= 1'b0;
      r_sdat  <= '0;
      r_oe    <= 1'b0;
      r_saddr <= '0;
      r_bsel  <= '1;
      r_ncs   <= 1'b1;
      r_noe   <= 1'b1;
      r_nwe   <= 1'b1;
    end else begin
      if (w_idle && w_req) begin
        r_dat_o <= 32'd0;
      end else if (w_cap) begin
        r_dat_o <= w_cap_dat;
      end
      r_ack <= (w_nxt == S_ACK);
      r_ncs <= ~w_acc;
      r_noe <= ~(w_nxt == S_RSTRB);
      r_nwe <= ~(w_nxt == S_WSTRB);
      r_oe  <= w_wr;
      if (w_acc) begin
        r_saddr <= w_sa;
        r_bsel  <= w_sb;
      end else begin
        r_bsel  <= '1;
      end
      if (w_wr) begin
        r_sdat <= w_sd;
      end
    end
  end

  assign wb_dat_o      = r_dat_o;
  assign wb_ack_o      = r_ack;
  assign sram_dat_o    = r_sdat;
  assign sram_dat_oe_o = r_oe;
  assign sram_addr_o   = r_saddr;
  assign sram_bsel_o   = r_bsel;
  assign sram_ncs_o    = r_ncs;
  assign sram_noe_o    = r_noe;
  assign sram_nwe_o    = r_nwe;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: a 32-bit and a 16-bit instance on SRAM models,
// checked against a byte-addressed big-endian memory model.
module tb_wb_sram_ctrl;

  localparam int AW  = 18;
  localparam int R32 = 1;
  localparam int W32 = 1;
  localparam int R16 = 1;
  localparam int W16 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tgt = 1'b0;
  logic        m_cyc = 1'b0;
  logic        m_stb = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = '0;
  logic [31:0] m_dat = '0;
  logic [3:0]  m_sel = '0;

  logic [31:0]   a_dato, a_sdi, a_sdo;
  logic          a_ack, a_oe, a_ncs, a_noe, a_nwe;
  logic [AW-1:0] a_addr;
  logic [3:0]    a_bsel;
  logic [31:0]   b_dato;
  logic [15:0]   b_sdi, b_sdo;
  logic          b_ack, b_oe, b_ncs, b_noe, b_nwe;
  logic [AW-1:0] b_addr;
  logic [1:0]    b_bsel;

  wb_sram_ctrl #(.AW(AW), .SRAM_DW(32), .RD_WAIT(R32), .WR_WAIT(W32)) u32 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(m_cyc & ~tgt), .wb_stb_i(m_stb & ~tgt), .wb_we_i(m_we),
    .wb_adr_i(m_adr), .wb_sel_i(m_sel), .wb_dat_i(m_dat),
    .wb_dat_o(a_dato), .wb_ack_o(a_ack),
    .sram_dat_i(a_sdi), .sram_dat_o(a_sdo), .sram_dat_oe_o(a_oe),
    .sram_addr_o(a_addr), .sram_bsel_o(a_bsel),
    .sram_ncs_o(a_ncs), .sram_noe_o(a_noe), .sram_nwe_o(a_nwe));

  wb_sram_ctrl #(.AW(AW), .SRAM_DW(16), .RD_WAIT(R16), .WR_WAIT(W16)) u16 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(m_cyc & tgt), .wb_stb_i(m_stb & tgt), .wb_we_i(m_we),
    .wb_adr_i(m_adr), .wb_sel_i(m_sel), .wb_dat_i(m_dat),
    .wb_dat_o(b_dato), .wb_ack_o(b_ack),
    .sram_dat_i(b_sdi), .sram_dat_o(b_sdo), .sram_dat_oe_o(b_oe),
    .sram_addr_o(b_addr), .sram_bsel_o(b_bsel),
    .sram_ncs_o(b_ncs), .sram_noe_o(b_noe), .sram_nwe_o(b_nwe));

  // Asynchronous SRAM models; reads float unless the chip is output-enabled
  logic [31:0] mem32 [64];
  logic [15:0] mem16 [128];
  logic        mem_init = 1'b1;

  assign a_sdi = (!a_ncs && !a_noe) ? mem32[a_addr[5:0]] : 'x;
  assign b_sdi = (!b_ncs && !b_noe) ? mem16[b_addr[6:0]] : 'x;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem32[i] <= '0;
      for (int i = 0; i < 128; i++) mem16[i] <= '0;
    end else begin
      if (!a_ncs && !a_nwe)
        for (int i = 0; i < 4; i++)
          if (!a_bsel[i]) mem32[a_addr[5:0]][8*i +: 8] <= a_sdo[8*i +: 8];
      if (!b_ncs && !b_nwe)
        for (int i = 0; i < 2; i++)
          if (!b_bsel[i]) mem16[b_addr[6:0]][8*i +: 8] <= b_sdo[8*i +: 8];
    end
  end

  logic          s_ncs, s_noe, s_nwe, s_oe, s_ack;
  logic [31:0]   s_dato, s_sdo;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_bsel;
  assign s_ncs  = tgt ? b_ncs : a_ncs;
  assign s_noe  = tgt ? b_noe : a_noe;
  assign s_nwe  = tgt ? b_nwe : a_nwe;
  assign s_oe   = tgt ? b_oe : a_oe;
  assign s_ack  = tgt ? b_ack : a_ack;
  assign s_dato = tgt ? b_dato : a_dato;
  assign s_sdo  = tgt ? {16'h0, b_sdo} : a_sdo;
  assign s_addr = tgt ? b_addr : a_addr;
  assign s_bsel = tgt ? {2'b11, b_bsel} : a_bsel;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one logical byte memory per instance, byte 0 = MSB lane
  logic [7:0] refm [2][256];

  function automatic logic [31:0] ref_rd(input bit t, input int w,
                                         input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = sel[3-i] ? refm[t][w*4+i] : 8'h00;
    return r;
  endfunction

  task automatic ref_wr(input bit t, input int w, input logic [3:0] sel,
                        input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (sel[3-i]) refm[t][w*4+i] = d[31-8*i -: 8];
  endtask

  function automatic int nhalves(input bit t, input logic [3:0] sel);
    if (t) return int'(|sel[3:2]) + int'(|sel[1:0]);
    return int'(sel != 4'd0);
  endfunction

  function automatic int exp_ack(input bit t, input bit we,
                                 input logic [3:0] sel);
    int nh, r, w;
    nh = nhalves(t, sel);
    r  = t ? R16 : R32;
    w  = t ? W16 : W32;
    if (nh == 0) return 1;
    if (!we) return (nh == 2) ? 2*r + 4 : r + 2;
    return (nh == 2) ? 2*w + 8 : w + 4;
  endfunction

  int            ackc, n_bursts, n_nwe, n_noe, n_viol;
  logic          prev_ncs;
  logic [31:0]   rdat;
  logic [AW-1:0] bur_addr [2];
  logic [3:0]    bur_bsel [2];
  logic [31:0]   bur_dat  [2];

  task automatic mon_reset();
    ackc = -1; n_bursts = 0; n_nwe = 0; n_noe = 0; n_viol = 0;
    prev_ncs = 1'b1; rdat = 'x;
  endtask

  task automatic mon();
    int bi;
    if (!s_ncs && prev_ncs) begin
      if (n_bursts < 2) begin
        bur_addr[n_bursts] = s_addr;
        bur_bsel[n_bursts] = s_bsel;
        bur_dat[n_bursts]  = s_sdo;
      end
      n_bursts++;
    end
    bi = (n_bursts > 2 ? 2 : n_bursts) - 1;
    if (!s_nwe) begin
      n_nwe++;
      if (s_ncs || !s_oe || bi < 0) n_viol++;
      else if (s_addr !== bur_addr[bi] || s_bsel !== bur_bsel[bi] ||
               s_sdo !== bur_dat[bi]) n_viol++;
    end
    if (!s_noe) n_noe++;
    if (s_ack && (!s_ncs || !s_nwe || !s_noe || s_oe)) n_viol++;
    prev_ncs = s_ncs;
  endtask

  task automatic txn(input bit t, input bit we, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] d);
    @(negedge clk);
    tgt = t; m_we = we; m_adr = adr; m_sel = sel; m_dat = d;
    m_cyc = 1'b1; m_stb = 1'b1;
    mon_reset();
    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      mon();
      if (s_ack) begin
        ackc = k + 1;
        rdat = s_dato;
        break;
      end
    end
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  task automatic run(input bit t, input bit we, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] d);
    int w, nh;
    w  = int'(adr[7:2]);
    nh = nhalves(t, sel);
    txn(t, we, adr, sel, d);
    chk($sformatf("ack_cycle t%0d we%0d sel%h", t, we, sel), ackc,
        exp_ack(t, we, sel));
    chk($sformatf("ncs_bursts t%0d", t), n_bursts, nh);
    chk($sformatf("nwe_low t%0d", t), n_nwe,
        we ? nh * ((t ? W16 : W32) + 1) : 0);
    chk($sformatf("noe_low t%0d", t), n_noe,
        we ? 0 : nh * ((t ? R16 : R32) + 1));
    chk($sformatf("protocol t%0d", t), n_viol, 0);
    if (!we) chk($sformatf("rdata t%0d adr%h", t, adr), rdat,
                 ref_rd(t, w, sel));
    else ref_wr(t, w, sel, d);
  endtask

  initial begin
    bit ack_seen;
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 256; i++) refm[t][i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes32", {a_ncs, a_noe, a_nwe, a_oe, a_ack}, 5'b11100);
    chk("rst_strobes16", {b_ncs, b_noe, b_nwe, b_oe, b_ack}, 5'b11100);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_bsel32", a_bsel, 4'hF);
    chk("rst_bsel16", b_bsel, 2'b11);
    chk("rst_vals32", {a_dato, a_addr, a_sdo}, '0);
    chk("rst_vals16", {b_dato, b_addr, b_sdo}, '0);

    run(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    chk("w32_addr", bur_addr[0], 4);
    chk("w32_mem", mem32[4], 32'hDEADBEEF);
    run(0, 0, 32'h10, 4'hF, 32'h0);
    chk("r32_ack", ackc, 3);
    chk("r32_data", rdat, 32'hDEADBEEF);

    run(1, 1, 32'h8, 4'hF, 32'h12345678);
    chk("w16_addr0", bur_addr[0], 4);
    chk("w16_addr1", bur_addr[1], 5);
    chk("w16_dat0", bur_dat[0], 32'h1234);
    chk("w16_dat1", bur_dat[1], 32'h5678);
    chk("w16_mem", {mem16[4], mem16[5]}, 32'h12345678);
    run(1, 0, 32'h8, 4'hF, 32'h0);
    chk("r16_ack", ackc, 6);
    chk("r16_data", rdat, 32'h12345678);

    run(1, 1, 32'h20, 4'b0011, 32'hAAAA5555);
    chk("skip_addr", bur_addr[0], 17);
    chk("skip_mem", {mem16[16], mem16[17]}, 32'h00005555);
    run(1, 0, 32'h20, 4'b0000, 32'h0);
    run(0, 1, 32'h14, 4'b0000, 32'hFFFFFFFF);
    chk("sel0_mem", mem32[5], 32'h0);

    run(0, 1, 32'h10, 4'b0100, 32'h00AB0000);
    chk("byte_bsel", bur_bsel[0], 4'b1011);
    chk("byte_mem", mem32[4], 32'hDEABBEEF);

    // Abort during the first half of a split write
    @(negedge clk);
    tgt = 1'b1; m_we = 1'b1; m_adr = 32'h24; m_sel = 4'hF;
    m_dat = 32'hCAFEF00D; m_cyc = 1'b1; m_stb = 1'b1;
    mon_reset();
    ack_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      mon();
      if (s_ack) ack_seen = 1'b1;
      if (k == 1) begin
        m_cyc = 1'b0; m_stb = 1'b0;
      end
    end
    chk("abort_no_ack", ack_seen, 1'b0);
    chk("abort_bursts", n_bursts, 1);
    chk("abort_nwe", n_nwe, W16 + 1);
    chk("abort_protocol", n_viol, 0);
    chk("abort_mem", {mem16[18], mem16[19]}, 32'hCAFE0000);
    ref_wr(1, 9, 4'b1100, 32'hCAFEF00D);
    run(1, 0, 32'h24, 4'hF, 32'h0);

    // Asynchronous reset while the write strobe is low
    @(negedge clk);
    tgt = 1'b0; m_we = 1'b1; m_adr = 32'h3C; m_sel = 4'hF;
    m_dat = 32'h55AA55AA; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_nwe_low", a_nwe, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_strobes", {a_nwe, a_ncs, a_oe, a_ack}, 4'b1100);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    rst_n = 1'b1;
    run(0, 0, 32'h10, 4'hF, 32'h0);

    for (int i = 0; i < 80; i++) begin
      bit          t, we;
      logic [31:0] adr, d;
      logic [3:0]  sel;
      t   = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      adr = 32'($urandom_range(0, 14)) << 2;
      sel = 4'($urandom_range(0, 15));
      d   = $urandom;
      run(t, we, adr, sel, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
